// File: rtl/psr_cond_unit_if.sv
// rtl/psr_cond_unit_if.sv - flag, write, scoreboard and condition signals between pipeline and PSR stage
interface psr_cond_unit_if #(
    parameter int PEND_MAX = 3
);
    localparam int CW = $clog2(PEND_MAX + 1);

    logic [3:0]    Flags_In;
    logic          Upd_Valid;
    logic          Wr_En;
    logic [3:0]    Wr_Data;
    logic          Set_Issue;
    logic          Cond_Valid;
    logic [3:0]    Cond;
    logic [3:0]    Flags_Out;
    logic          C_Out;
    logic          Cond_Stall;
    logic          Cond_Done;
    logic          Cond_Pass;
    logic [CW-1:0] Pend_Cnt;
    logic          Err;

    modport master (
        output Flags_In, Upd_Valid, Wr_En, Wr_Data, Set_Issue, Cond_Valid, Cond,
        input  Flags_Out, C_Out, Cond_Stall, Cond_Done, Cond_Pass, Pend_Cnt, Err
    );

    modport slave (
        input  Flags_In, Upd_Valid, Wr_En, Wr_Data, Set_Issue, Cond_Valid, Cond,
        output Flags_Out, C_Out, Cond_Stall, Cond_Done, Cond_Pass, Pend_Cnt, Err
    );
endinterface

// File: rtl/psr_cond_unit.sv
// rtl/psr_cond_unit.sv - program status register, condition evaluation and flag-setter scoreboard
module psr_cond_unit #(
    parameter int         PEND_MAX    = 3,
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic             Clk,
    input  logic             Reset_n,
    psr_cond_unit_if.slave   bus
);
    localparam int            CW      = $clog2(PEND_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(PEND_MAX);
    localparam logic [CW-1:0] ONE     = CW'(1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state, state_next;
    logic [3:0]    psr;
    logic [3:0]    eff;
    logic [CW-1:0] cnt, cnt_next;
    logic          err, err_next;
    logic          done, pass;
    logic          result;
    logic          stall;
    logic          n, z, c, v;

    // Flags seen by the condition check: a write or retiring update this cycle bypasses the register
    always_comb begin
        eff = psr;
        if (bus.Wr_En)
            eff = bus.Wr_Data;
        else if (bus.Upd_Valid)
            eff = bus.Flags_In;
        {n, z, c, v} = eff;
    end

    // Condition table on the effective flags
    always_comb begin
        result = 1'b0;
        case (bus.Cond)
            4'h0: result = z;
            4'h1: result = !z;
            4'h2: result = c;
            4'h3: result = !c;
            4'h4: result = n;
            4'h5: result = !n;
            4'h6: result = v;
            4'h7: result = !v;
            4'h8: result = c & !z;
            4'h9: result = !c | z;
            4'hA: result = (n == v);
            4'hB: result = (n != v);
            4'hC: result = !z & (n == v);
            4'hD: result = z | (n != v);
            4'hE: result = 1'b1;
            default: result = 1'b0;
        endcase
    end

    // Hold decode while an older flag-setter (including one issuing now) has not retired; AL/NV never wait
    always_comb begin
        stall = bus.Cond_Valid & (bus.Cond[3:1] != 3'b111) &
                (bus.Set_Issue | ((state == BUSY) & ((cnt > ONE) | !bus.Upd_Valid)));
    end

    // Scoreboard next count with saturation at both ends flagging an error
    always_comb begin
        cnt_next = cnt;
        err_next = err;
        if (bus.Set_Issue && !bus.Upd_Valid) begin
            if (cnt == CNT_MAX)
                err_next = 1'b1;
            else
                cnt_next = cnt + ONE;
        end else if (bus.Upd_Valid && !bus.Set_Issue) begin
            if (cnt == '0)
                err_next = 1'b1;
            else
                cnt_next = cnt - ONE;
        end
    end

    // IDLE/BUSY next state follows whether any flag-setter remains outstanding
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cnt_next != '0) state_next = BUSY;
            BUSY:    if (cnt_next == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Scoreboard and FSM state registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            err   <= err_next;
        end
    end

    // PSR: direct write beats retiring update, otherwise hold
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            psr <= RESET_FLAGS;
        else if (bus.Wr_En)
            psr <= bus.Wr_Data;
        else if (bus.Upd_Valid)
            psr <= bus.Flags_In;
    end

    // Registered condition result, one cycle after an unstalled request
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            done <= 1'b0;
            pass <= 1'b0;
        end else begin
            done <= bus.Cond_Valid & !stall;
            pass <= bus.Cond_Valid & !stall & result;
        end
    end

    assign bus.Flags_Out  = psr;
    assign bus.C_Out      = psr[1];
    assign bus.Cond_Stall = stall;
    assign bus.Cond_Done  = done;
    assign bus.Cond_Pass  = pass;
    assign bus.Pend_Cnt   = cnt;
    assign bus.Err        = err;
endmodule

// File: tb/tb_psr_cond_unit.sv
// tb/tb_psr_cond_unit.sv - directed self-checking bench for psr_cond_unit
module tb_psr_cond_unit;
    logic Clk;
    logic Reset_n;
    int   checks;
    int   errors;

    psr_cond_unit_if #(.PEND_MAX(3)) bus ();

    psr_cond_unit #(
        .PEND_MAX    (3),
        .RESET_FLAGS (4'b0000)
    ) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.Flags_In   = 4'b0000;
        bus.Upd_Valid  = 1'b0;
        bus.Wr_En      = 1'b0;
        bus.Wr_Data    = 4'b0000;
        bus.Set_Issue  = 1'b0;
        bus.Cond_Valid = 1'b0;
        bus.Cond       = 4'h0;
    endtask

    function automatic logic exp_cond(input logic [3:0] cc, input logic [3:0] f);
        logic fn, fz, fc, fv, base;
        {fn, fz, fc, fv} = f;
        case (cc[3:1])
            3'd0: base = fz;
            3'd1: base = fc;
            3'd2: base = fn;
            3'd3: base = fv;
            3'd4: base = fc & ~fz;
            3'd5: base = ~(fn ^ fv);
            3'd6: base = ~fz & ~(fn ^ fv);
            default: base = 1'b1;
        endcase
        return cc[0] ? ~base : base;
    endfunction

    initial begin
        checks  = 0;
        errors  = 0;
        Reset_n = 1'b0;
        idle_inputs();

        #3;
        chk("rst_flags", 8'(bus.Flags_Out), 8'h0);
        chk("rst_cout", 8'(bus.C_Out), 8'h0);
        chk("rst_pend", 8'(bus.Pend_Cnt), 8'h0);
        chk("rst_done", 8'(bus.Cond_Done), 8'h0);
        chk("rst_pass", 8'(bus.Cond_Pass), 8'h0);
        chk("rst_err", 8'(bus.Err), 8'h0);
        #9;
        Reset_n = 1'b1;
        cycle();

        bus.Cond_Valid = 1'b1;
        bus.Cond       = 4'hE;
        #1;
        chk("al_stall", 8'(bus.Cond_Stall), 8'h0);
        cycle();
        chk("al_done", 8'(bus.Cond_Done), 8'h1);
        chk("al_pass", 8'(bus.Cond_Pass), 8'h1);
        bus.Cond = 4'hF;
        cycle();
        chk("nv_done", 8'(bus.Cond_Done), 8'h1);
        chk("nv_pass", 8'(bus.Cond_Pass), 8'h0);
        bus.Cond_Valid = 1'b0;
        cycle();
        chk("idle_done", 8'(bus.Cond_Done), 8'h0);

        bus.Set_Issue = 1'b1;
        cycle();
        chk("byp_pend1", 8'(bus.Pend_Cnt), 8'h1);
        bus.Set_Issue  = 1'b0;
        bus.Upd_Valid  = 1'b1;
        bus.Flags_In   = 4'b0100;
        bus.Cond_Valid = 1'b1;
        bus.Cond       = 4'h0;
        #1;
        chk("byp_stall", 8'(bus.Cond_Stall), 8'h0);
        cycle();
        idle_inputs();
        chk("byp_done", 8'(bus.Cond_Done), 8'h1);
        chk("byp_pass", 8'(bus.Cond_Pass), 8'h1);
        chk("byp_flags", 8'(bus.Flags_Out), 8'h4);
        chk("byp_pend0", 8'(bus.Pend_Cnt), 8'h0);

        bus.Set_Issue  = 1'b1;
        bus.Cond_Valid = 1'b1;
        bus.Cond       = 4'h0;
        #1;
        chk("same_issue_stall", 8'(bus.Cond_Stall), 8'h1);
        bus.Cond = 4'hE;
        #1;
        chk("same_issue_al", 8'(bus.Cond_Stall), 8'h0);
        bus.Cond = 4'h8;
        cycle();
        bus.Set_Issue = 1'b0;
        #1;
        chk("hi_stall_a", 8'(bus.Cond_Stall), 8'h1);
        cycle();
        chk("hi_nodone", 8'(bus.Cond_Done), 8'h0);
        chk("hi_stall_b", 8'(bus.Cond_Stall), 8'h1);
        bus.Upd_Valid = 1'b1;
        bus.Flags_In  = 4'b0010;
        #1;
        chk("hi_release", 8'(bus.Cond_Stall), 8'h0);
        cycle();
        idle_inputs();
        chk("hi_done", 8'(bus.Cond_Done), 8'h1);
        chk("hi_pass", 8'(bus.Cond_Pass), 8'h1);
        chk("hi_flags", 8'(bus.Flags_Out), 8'h2);
        chk("hi_cout", 8'(bus.C_Out), 8'h1);
        chk("hi_pend", 8'(bus.Pend_Cnt), 8'h0);

        bus.Wr_En      = 1'b1;
        bus.Cond_Valid = 1'b1;
        for (int f = 0; f < 16; f++) begin
            for (int k = 0; k < 16; k++) begin
                bus.Wr_Data = 4'(f);
                bus.Cond    = 4'(k);
                cycle();
                chk($sformatf("sweep_done_f%0h_c%0h", f, k), 8'(bus.Cond_Done), 8'h1);
                chk($sformatf("sweep_pass_f%0h_c%0h", f, k), 8'(bus.Cond_Pass),
                    8'(exp_cond(4'(k), 4'(f))));
            end
        end
        idle_inputs();
        chk("sweep_flags", 8'(bus.Flags_Out), 8'hF);

        bus.Wr_En     = 1'b1;
        bus.Wr_Data   = 4'b1010;
        bus.Upd_Valid = 1'b1;
        bus.Flags_In  = 4'b0101;
        bus.Set_Issue = 1'b1;
        cycle();
        idle_inputs();
        chk("prio_flags", 8'(bus.Flags_Out), 8'hA);
        chk("prio_pend", 8'(bus.Pend_Cnt), 8'h0);
        chk("prio_err", 8'(bus.Err), 8'h0);

        bus.Set_Issue = 1'b1;
        cycle();
        chk("sat_pend1", 8'(bus.Pend_Cnt), 8'h1);
        cycle();
        chk("sat_pend2", 8'(bus.Pend_Cnt), 8'h2);
        cycle();
        chk("sat_pend3", 8'(bus.Pend_Cnt), 8'h3);
        chk("sat_err_pre", 8'(bus.Err), 8'h0);
        cycle();
        chk("sat_pend4", 8'(bus.Pend_Cnt), 8'h3);
        chk("sat_err", 8'(bus.Err), 8'h1);
        bus.Set_Issue = 1'b0;
        bus.Wr_En     = 1'b1;
        bus.Wr_Data   = 4'b1111;
        cycle();
        idle_inputs();
        chk("wr_busy_flags", 8'(bus.Flags_Out), 8'hF);
        chk("wr_busy_pend", 8'(bus.Pend_Cnt), 8'h3);

        Reset_n = 1'b0;
        #2;
        Reset_n = 1'b1;
        cycle();
        chk("rst2_err", 8'(bus.Err), 8'h0);
        bus.Upd_Valid = 1'b1;
        bus.Flags_In  = 4'b1001;
        cycle();
        idle_inputs();
        chk("under_pend", 8'(bus.Pend_Cnt), 8'h0);
        chk("under_err", 8'(bus.Err), 8'h1);
        chk("under_flags", 8'(bus.Flags_Out), 8'h9);

        bus.Set_Issue = 1'b1;
        cycle();
        cycle();
        bus.Set_Issue = 1'b0;
        chk("mid_pend2", 8'(bus.Pend_Cnt), 8'h2);
        bus.Cond_Valid = 1'b1;
        bus.Cond       = 4'h0;
        #1;
        chk("mid_stall", 8'(bus.Cond_Stall), 8'h1);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("mid_pend", 8'(bus.Pend_Cnt), 8'h0);
        chk("mid_err", 8'(bus.Err), 8'h0);
        chk("mid_flags", 8'(bus.Flags_Out), 8'h0);
        chk("mid_stall_clr", 8'(bus.Cond_Stall), 8'h0);
        cycle();
        chk("mid_done", 8'(bus.Cond_Done), 8'h0);
        chk("mid_pass", 8'(bus.Cond_Pass), 8'h0);
        idle_inputs();
        Reset_n = 1'b1;
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/psr_cond_unit.md
Name: psr_cond_unit

Overview:
Program status register and condition-evaluation stage directly downstream of the 32-bit ALU. It captures the ALU's N/Z/C/V flags when a flag-setting instruction retires and feeds the registered carry back to the ALU carry input. It also evaluates the 4-bit condition field of the instruction in decode against the current flags, with same-cycle bypass from the ALU. A small scoreboard stalls conditional instructions while flag-setting instructions are still in flight.

Parameters:
PEND_MAX, 3, maximum number of outstanding flag-setting instructions tracked (counter width = clog2(PEND_MAX+1))
RESET_FLAGS, 4'b0000, reset value of {N,Z,C,V}

Ports:
Clk  input  1  rising-edge clock
Reset_n  input  1  asynchronous active-low reset
Flags_In  input  4  {N,Z,C,V} from ALU, same order as ALU flag outputs
Upd_Valid  input  1  a flag-setting instruction retires this cycle; Flags_In is valid
Wr_En  input  1  direct PSR write (move-to-status)
Wr_Data  input  4  {N,Z,C,V} for direct write
Set_Issue  input  1  a flag-setting instruction leaves decode this cycle
Cond_Valid  input  1  decode presents a conditional instruction
Cond  input  4  condition field
Flags_Out  output  4  registered {N,Z,C,V}
C_Out  output  1  Flags_Out carry bit, to ALU C_In
Cond_Stall  output  1  combinational; decode must hold
Cond_Done  output  1  registered; Cond_Pass is valid this cycle
Cond_Pass  output  1  registered condition result
Pend_Cnt  output  clog2(PEND_MAX+1)  outstanding flag-setters
Err  output  1  sticky scoreboard over/underflow

Behaviour:
- Reset (Reset_n low, async): Flags_Out=RESET_FLAGS, Pend_Cnt=0, Cond_Done=0, Cond_Pass=0, Err=0. Deassertion is sampled on the next Clk edge.
- PSR update each edge:
  - Wr_En takes priority and loads Wr_Data.
  - Otherwise, Upd_Valid loads Flags_In.
  - Otherwise, the PSR holds.
- Effective flags (combinational): Wr_En ? Wr_Data : Upd_Valid ? Flags_In : Flags_Out. This gives bypass with zero added latency.
- Condition table (result on effective flags):
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C
  - 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
  - 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V
  - C GT !Z&(N==V); D LE Z|(N!=V); E AL 1; F NV 0
- Scoreboard counter:
  - +1 on Set_Issue, -1 on Upd_Valid. Both in the same cycle leave it unchanged.
  - Set_Issue at PEND_MAX without Upd_Valid: count saturates and Err sets.
  - Upd_Valid at 0 without Set_Issue: count stays 0 and Err sets.
  - Err clears only on reset.
- Cond_Stall = Cond_Valid & (Pend_Cnt > 1, or Pend_Cnt==1 & !Upd_Valid, or Set_Issue). Set_Issue in the same cycle is treated as an older instruction by ordering rule. Cond AL and NV never stall.
- Evaluation: Cond_Valid & !Cond_Stall at edge k gives Cond_Done=1 and Cond_Pass=result at edge k+1, a 1-cycle latency. Otherwise Cond_Done=0 and Cond_Pass=0.
- FSM over Pend_Cnt:
  - IDLE (0): goes to BUSY on Set_Issue.
  - BUSY (1..PEND_MAX): returns to IDLE when the count reaches 0.
  - No other state is held.
- Wr_En while Pend_Cnt>0 is legal. It updates the PSR but does not change the counter.
- Reset mid-stall clears everything; any pending evaluation is dropped (Cond_Done=0).

Test Plan:
- Reset, then Cond_Valid with Cond=E (AL) -> next cycle Cond_Done=1, Cond_Pass=1; Cond=F -> Cond_Pass=0; Flags_Out=0000, C_Out=0.
- Upd_Valid with Flags_In=0100 and Cond_Valid Cond=0 (EQ) in the same cycle, Pend_Cnt=1 -> Cond_Stall=0, next cycle Cond_Pass=1, Flags_Out=0100, Pend_Cnt=0.
- Set_Issue, then Cond_Valid Cond=8 (HI) -> Cond_Stall=1 until Upd_Valid with Flags_In=0010 -> Cond_Pass=1 the following cycle.
- Sweep all 16 Cond values over all 16 flag values loaded via Wr_En -> Cond_Pass matches the condition table; Wr_En=1 with Upd_Valid=1 -> Wr_Data wins.
- Four Set_Issue pulses with PEND_MAX=3 -> Pend_Cnt=3, Err=1; a stray Upd_Valid at count 0 also sets Err.
- Reset_n asserted low mid-cycle with Pend_Cnt=2 and Cond_Stall=1 -> outputs clear immediately, without waiting for a clock edge.
